// File: rtl/div39_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div39_pkg
//  Brief    : Shared constants and state encoding for the 39-bit restoring
//             divider (width default, iteration count, counter width).
//  Revision : 1.0 - initial release
// ============================================================================
package div39_pkg;

  // MSB index of every data bus; operands are WIDTH_DEFAULT+1 = 39 bits
  localparam int WIDTH_DEFAULT = 38;
  // One quotient bit per iteration
  localparam int ITER          = WIDTH_DEFAULT + 1;
  // Iteration counter width, enough to hold ITER-1
  localparam int CNT_W         = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : div39_pkg
`default_nettype wire

// File: rtl/div39_restoring_if.sv
`default_nettype none
// ============================================================================
//  Module   : div39_restoring_if
//  Brief    : Request/response valid-ready bundle of the restoring divider.
//             The master side drives operands and accepts results.
//  Revision : 1.0 - initial release
// ============================================================================
interface div39_restoring_if
  import div39_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   dividend;
  logic [WIDTH:0]   divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   quotient;
  logic [WIDTH:0]   remainder;
  logic             div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );

endinterface : div39_restoring_if
`default_nettype wire

// File: rtl/div39_step.sv
`default_nettype none
// ============================================================================
//  Module   : div39_step
//  Brief    : One restoring-division step: trial subtraction R' - D done as
//             R' + ~D + 1; keeps R' when the subtraction borrows.
//  Revision : 1.0 - initial release
// ============================================================================
module div39_step
  import div39_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH+1:0] r_shift,
  input  logic [WIDTH:0]   d,
  output logic [WIDTH+1:0] r_next,
  output logic             q_bit,
  output logic             borrow
);

  localparam logic [WIDTH+2:0] C_ONE = {{(WIDTH+2){1'b0}}, 1'b1};

  logic [WIDTH+2:0] sum;
  logic             carry;

  // Two's-complement trial subtraction with an extra carry bit; no carry out means R' < D
  always_comb begin
    sum    = {1'b0, r_shift} + {1'b0, ~{1'b0, d}} + C_ONE;
    carry  = sum[WIDTH+2];
    borrow = ~carry;
    q_bit  = carry;
    r_next = carry ? sum[WIDTH+1:0] : r_shift;
  end

endmodule : div39_step
`default_nettype wire

// File: rtl/div39_restoring.sv
`default_nettype none
// ============================================================================
//  Module   : div39_restoring
//  Brief    : Iterative unsigned restoring divider, one quotient bit per clock,
//             MSB first. One operation in flight, valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module div39_restoring
  import div39_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  wire               clk,
  input  wire               rst,
  div39_restoring_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH:0]     n_q,     n_d;     // dividend, shifted left so the next bit is the MSB
  logic [WIDTH:0]     d_q,     d_d;     // divisor latched at accept
  logic [WIDTH+1:0]   r_q,     r_d;     // partial remainder
  logic [WIDTH:0]     qw_q,    qw_d;    // quotient under construction
  logic [WIDTH:0]     quo_q,   quo_d;   // published quotient
  logic [WIDTH:0]     rem_q,   rem_d;   // published remainder
  logic               dz_q,    dz_d;    // published divide-by-zero flag

  logic [WIDTH+1:0]   r_shift;
  logic [WIDTH+1:0]   step_r;
  logic               step_q;
  logic               step_borrow;

  // Bring in the next dividend bit: R' = {R[WIDTH:0], N-bit}
  always_comb begin
    r_shift = (r_q << 1) | {{(WIDTH+1){1'b0}}, n_q[WIDTH]};
  end

  div39_step #(
    .WIDTH   (WIDTH)
  ) u_step (
    .r_shift (r_shift),
    .d       (d_q),
    .r_next  (step_r),
    .q_bit   (step_q),
    .borrow  (step_borrow)
  );

  // Next-state, datapath and result-register update for the divide sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    qw_d    = qw_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          n_d  = bus.dividend;
          d_d  = bus.divisor;
          r_d  = '0;
          qw_d = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            // Zero divisor needs no iterations: publish the fixed result at once
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        n_d   = n_q << 1;
        r_d   = step_r;
        qw_d  = (qw_q << 1) | {{WIDTH{1'b0}}, step_q};
        cnt_d = cnt_q + C_CNT_ONE;
        if (cnt_q == C_LAST_CNT) begin
          // Remainder is always below D, so it fits the narrower output bus
          state_d = DONE;
          quo_d   = qw_d;
          rem_d   = r_d[WIDTH:0];
          dz_d    = 1'b0;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      qw_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      d_q     <= d_d;
      r_q     <= r_d;
      qw_q    <= qw_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;

endmodule : div39_restoring
`default_nettype wire
